// File: rtl/cache_mem_arbiter_pkg.sv
// Package: cache_mem_arbiter_pkg
// Purpose: Shared types and constants for the i/d cache to RAM arbiter.
//   word_t      - 32-bit memory word
//   ramstate_t  - status reported by the single-port RAM
//   arb_state_t - arbiter FSM state (which requester owns the RAM)
//   STARVE_LIM/CNT_W - default starvation limit and counter width
package cache_mem_arbiter_pkg;

  localparam int WORD_W           = 32;
  localparam int STARVE_LIM_DFLT  = 4;
  localparam int CNT_W_DFLT       = 3;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } arb_state_t;

endpackage

// File: rtl/cache_mem_arbiter.sv
// Module: cache_mem_arbiter
// Purpose: Arbitrates one shared single-port RAM between the icache and the
//   dcache. The data side has priority; a starvation counter forces an
//   instruction fetch after STARVE_LIM consecutive data completions while a
//   fetch is pending. One transaction is outstanding at a time and every
//   transaction returns to IDLE for one cycle before the next grant.
// Ports:
//   CLK, nRST                    - clock (rising edge), async active-low reset
//   iREN, iaddr                  - icache read request and word address
//   iwait, iload                 - icache wait (low on completion) and data
//   dREN, dWEN, daddr, dstore    - dcache read/write request, address, data
//   dwait, dload                 - dcache wait (low on completion) and data
//   ramREN, ramWEN, ramaddr,
//   ramstore                     - RAM strobes, address and write data
//   ramload, ramstate            - RAM read data and status
module cache_mem_arbiter
  import cache_mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIM = STARVE_LIM_DFLT,
  parameter int CNT_W      = CNT_W_DFLT
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [WORD_W-1:0] iaddr,
  output logic              iwait,
  output logic [WORD_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [WORD_W-1:0] daddr,
  input  logic [WORD_W-1:0] dstore,
  output logic              dwait,
  output logic [WORD_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [WORD_W-1:0] ramaddr,
  output logic [WORD_W-1:0] ramstore,
  input  logic [WORD_W-1:0] ramload,
  input  ramstate_t         ramstate
);

  localparam logic [CNT_W-1:0] LIM = CNT_W'(STARVE_LIM);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  arb_state_t        state_q, state_d;
  logic [CNT_W-1:0]  starve_q, starve_d;
  word_t             addr_q, addr_d;
  word_t             store_q, store_d;
  logic              wen_q, wen_d;

  logic              d_req;

  assign d_req = dREN | dWEN;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= IDLE;
      starve_q <= '0;
      addr_q   <= '0;
      store_q  <= '0;
      wen_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      addr_q   <= addr_d;
      store_q  <= store_d;
      wen_q    <= wen_d;
    end
  end

  // RAM outputs depend only on registered state, so they stay stable while
  // the RAM reports FREE/BUSY. Waits and load data are combinational on
  // ramstate so completion is visible in the ACCESS cycle itself.
  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    addr_d   = addr_q;
    store_d  = store_q;
    wen_d    = wen_q;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = 1'b1;
    dwait    = 1'b1;
    iload    = '0;
    dload    = '0;

    case (state_q)
      IDLE: begin
        // A saturated counter with a pending fetch overrides data priority.
        if ((starve_q == LIM) && iREN) begin
          state_d = GNT_I;
          addr_d  = iaddr;
          store_d = dstore;
          wen_d   = dWEN;
        end else if (d_req) begin
          state_d = GNT_D;
          addr_d  = daddr;
          store_d = dstore;
          wen_d   = dWEN;
        end else if (iREN) begin
          state_d = GNT_I;
          addr_d  = iaddr;
          store_d = dstore;
          wen_d   = dWEN;
        end
      end

      GNT_I: begin
        ramREN   = 1'b1;
        ramaddr  = addr_q;
        ramstore = store_q;
        // A dropped request wins over a same-cycle ACCESS: nobody wants it.
        if (!iREN) begin
          state_d = IDLE;
        end else if (ramstate == ACCESS) begin
          iwait    = 1'b0;
          iload    = ramload;
          state_d  = IDLE;
          starve_d = '0;
        end else if (ramstate == ERROR) begin
          state_d = IDLE;
        end
      end

      GNT_D: begin
        ramWEN   = wen_q;
        ramREN   = ~wen_q;
        ramaddr  = addr_q;
        ramstore = store_q;
        if (!d_req) begin
          state_d = IDLE;
        end else if (ramstate == ACCESS) begin
          dwait   = 1'b0;
          dload   = ramload;
          state_d = IDLE;
          // Count D completions that happen while a fetch is waiting.
          if (!iREN) begin
            starve_d = '0;
          end else if (starve_q < LIM) begin
            starve_d = starve_q + ONE;
          end
        end else if (ramstate == ERROR) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Testbench: tb_cache_mem_arbiter
// Purpose: Directed, table-driven check of cache_mem_arbiter. Each table
//   record is one clock cycle of inputs plus the outputs expected in that
//   cycle. Starvation and asynchronous reset are exercised by hand-written
//   sequences after the table.
module tb_cache_mem_arbiter;
  import cache_mem_arbiter_pkg::*;

  logic              CLK;
  logic              nRST;
  logic              iREN;
  logic [WORD_W-1:0] iaddr;
  logic              iwait;
  logic [WORD_W-1:0] iload;
  logic              dREN;
  logic              dWEN;
  logic [WORD_W-1:0] daddr;
  logic [WORD_W-1:0] dstore;
  logic              dwait;
  logic [WORD_W-1:0] dload;
  logic              ramREN;
  logic              ramWEN;
  logic [WORD_W-1:0] ramaddr;
  logic [WORD_W-1:0] ramstore;
  logic [WORD_W-1:0] ramload;
  ramstate_t         ramstate;

  typedef struct {
    string     name;
    logic      i_ren;
    word_t     i_addr;
    logic      d_ren;
    logic      d_wen;
    word_t     d_addr;
    word_t     d_store;
    word_t     r_load;
    ramstate_t r_state;
    logic      e_iwait;
    word_t     e_iload;
    logic      e_dwait;
    word_t     e_dload;
    logic      e_ren;
    logic      e_wen;
    word_t     e_addr;
    word_t     e_store;
  } vec_t;

  int n_vectors = 0;
  int n_miscompares = 0;

  cache_mem_arbiter #(
    .STARVE_LIM(4),
    .CNT_W(3)
  ) dut (
    .CLK(CLK),
    .nRST(nRST),
    .iREN(iREN),
    .iaddr(iaddr),
    .iwait(iwait),
    .iload(iload),
    .dREN(dREN),
    .dWEN(dWEN),
    .daddr(daddr),
    .dstore(dstore),
    .dwait(dwait),
    .dload(dload),
    .ramREN(ramREN),
    .ramWEN(ramWEN),
    .ramaddr(ramaddr),
    .ramstore(ramstore),
    .ramload(ramload),
    .ramstate(ramstate)
  );

  // 10 time-unit clock, rising edges at 5, 15, 25, ...
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic vec_t mk(
    input string n, input logic ir, input word_t ia, input logic dr, input logic dw,
    input word_t da, input word_t ds, input word_t rl, input ramstate_t rs,
    input logic eiw, input word_t eil, input logic edw, input word_t edl,
    input logic er, input logic ew, input word_t ea, input word_t es);
    vec_t v;
    v.name = n;     v.i_ren = ir;    v.i_addr = ia;  v.d_ren = dr;
    v.d_wen = dw;   v.d_addr = da;   v.d_store = ds; v.r_load = rl;
    v.r_state = rs; v.e_iwait = eiw; v.e_iload = eil; v.e_dwait = edw;
    v.e_dload = edl; v.e_ren = er;   v.e_wen = ew;   v.e_addr = ea;
    v.e_store = es;
    return v;
  endfunction

  // IDLE cycle: every output at its quiet value regardless of the inputs.
  function automatic vec_t idle(
    input string n, input logic ir, input word_t ia, input logic dr, input logic dw,
    input word_t da, input word_t ds, input word_t rl, input ramstate_t rs);
    return mk(n, ir, ia, dr, dw, da, ds, rl, rs, 1'b1, 32'h0, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
  endfunction

  task automatic cmp(input string vname, input string field, input word_t got, input word_t exp);
    if (got !== exp) begin
      n_miscompares++;
      $display("[TB] FAIL %s %s: got %h expected %h", vname, field, got, exp);
    end
  endtask

  task automatic checkOutput(input vec_t v);
    n_vectors++;
    cmp(v.name, "iwait", {31'h0, iwait}, {31'h0, v.e_iwait});
    cmp(v.name, "iload", iload, v.e_iload);
    cmp(v.name, "dwait", {31'h0, dwait}, {31'h0, v.e_dwait});
    cmp(v.name, "dload", dload, v.e_dload);
    cmp(v.name, "ramREN", {31'h0, ramREN}, {31'h0, v.e_ren});
    cmp(v.name, "ramWEN", {31'h0, ramWEN}, {31'h0, v.e_wen});
    cmp(v.name, "ramaddr", ramaddr, v.e_addr);
    cmp(v.name, "ramstore", ramstore, v.e_store);
  endtask

  task automatic driveInputs(input vec_t v);
    iREN     = v.i_ren;
    iaddr    = v.i_addr;
    dREN     = v.d_ren;
    dWEN     = v.d_wen;
    daddr    = v.d_addr;
    dstore   = v.d_store;
    ramload  = v.r_load;
    ramstate = v.r_state;
  endtask

  // Called 1 unit after a rising edge: drive, check mid-cycle, advance.
  task automatic applyStimulus(input vec_t v);
    driveInputs(v);
    #4;
    checkOutput(v);
    @(posedge CLK);
    #1;
  endtask

  vec_t tbl[$];
  vec_t v;

  initial begin
    nRST = 1'b0;
    driveInputs(idle("init", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, FREE));
    #3;
    checkOutput(idle("reset", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, FREE));
    @(posedge CLK);
    #1;
    nRST = 1'b1;

    // I only: grant in cycle 0, two BUSY, ACCESS in cycle 3
    tbl.push_back(idle("i_req",   1, 32'h40, 0, 0, 0, 0, 0, FREE));
    tbl.push_back(mk("i_busy1",   1, 32'h40, 0, 0, 0, 0, 0, BUSY,   1, 0, 1, 0, 1, 0, 32'h40, 0));
    tbl.push_back(mk("i_busy2",   1, 32'h40, 0, 0, 0, 0, 0, BUSY,   1, 0, 1, 0, 1, 0, 32'h40, 0));
    tbl.push_back(mk("i_access",  1, 32'h40, 0, 0, 0, 0, 32'h8C010004, ACCESS,
                     0, 32'h8C010004, 1, 0, 1, 0, 32'h40, 0));
    tbl.push_back(idle("i_done",  0, 32'h40, 0, 0, 0, 0, 32'h8C010004, FREE));
    // D write; address/data change mid-grant must be ignored
    tbl.push_back(idle("d_req",   0, 0, 0, 1, 32'h100, 32'hDEADBEEF, 0, FREE));
    tbl.push_back(mk("d_busy",    0, 0, 0, 1, 32'h200, 32'h0, 0, BUSY,
                     1, 0, 1, 0, 0, 1, 32'h100, 32'hDEADBEEF));
    tbl.push_back(mk("d_access",  0, 0, 0, 1, 32'h200, 32'h0, 32'h12345678, ACCESS,
                     1, 0, 0, 32'h12345678, 0, 1, 32'h100, 32'hDEADBEEF));
    tbl.push_back(idle("d_done",  0, 0, 0, 0, 0, 0, 0, FREE));
    // Contention: D first, then I after one IDLE bubble
    tbl.push_back(idle("both_req", 1, 32'h44, 1, 0, 32'h300, 0, 0, FREE));
    tbl.push_back(mk("both_d_acc", 1, 32'h44, 1, 0, 32'h300, 0, 32'hAAAA5555, ACCESS,
                     1, 0, 0, 32'hAAAA5555, 1, 0, 32'h300, 0));
    tbl.push_back(idle("bubble",   1, 32'h44, 0, 0, 0, 0, 0, FREE));
    tbl.push_back(mk("both_i_acc", 1, 32'h44, 0, 0, 0, 0, 32'h11112222, ACCESS,
                     0, 32'h11112222, 1, 0, 1, 0, 32'h44, 0));
    tbl.push_back(idle("both_done", 0, 0, 0, 0, 0, 0, 0, FREE));
    // ERROR in GNT_D: no completion, automatic re-grant after IDLE
    tbl.push_back(idle("e_req",   0, 0, 1, 0, 32'h500, 0, 0, FREE));
    tbl.push_back(mk("e_error",   0, 0, 1, 0, 32'h500, 0, 32'h55555555, ERROR,
                     1, 0, 1, 0, 1, 0, 32'h500, 0));
    tbl.push_back(idle("e_idle",  0, 0, 1, 0, 32'h500, 0, 0, FREE));
    tbl.push_back(mk("e_retry",   0, 0, 1, 0, 32'h500, 0, 32'h0BADF00D, ACCESS,
                     1, 0, 0, 32'h0BADF00D, 1, 0, 32'h500, 0));
    tbl.push_back(idle("e_done",  0, 0, 0, 0, 0, 0, 0, FREE));
    // iREN dropped during GNT_I: abort, late ACCESS is not a completion
    tbl.push_back(idle("a_req",   1, 32'h60, 0, 0, 0, 0, 0, FREE));
    tbl.push_back(mk("a_busy",    1, 32'h60, 0, 0, 0, 0, 0, BUSY, 1, 0, 1, 0, 1, 0, 32'h60, 0));
    tbl.push_back(mk("a_drop",    0, 32'h60, 0, 0, 0, 0, 0, BUSY, 1, 0, 1, 0, 1, 0, 32'h60, 0));
    tbl.push_back(idle("a_idle",  0, 32'h60, 0, 0, 0, 0, 32'hFFFFFFFF, ACCESS));

    foreach (tbl[k]) applyStimulus(tbl[k]);

    // Starvation: both requesting continuously; 4 D completions, then I,
    // then D again (counter cleared by the I completion).
    for (int g = 1; g <= 6; g++) begin
      word_t rl;
      rl = 32'h1000 + word_t'(g);
      applyStimulus(idle($sformatf("starve_idle%0d", g), 1, 32'h80, 1, 0, 32'h900, 0, 0, FREE));
      if (g == 5)
        v = mk($sformatf("starve_acc%0d", g), 1, 32'h80, 1, 0, 32'h900, 0, rl, ACCESS,
               0, rl, 1, 0, 1, 0, 32'h80, 0);
      else
        v = mk($sformatf("starve_acc%0d", g), 1, 32'h80, 1, 0, 32'h900, 0, rl, ACCESS,
               1, 0, 0, rl, 1, 0, 32'h900, 0);
      applyStimulus(v);
    end

    // Async reset in the middle of a D write grant
    applyStimulus(idle("r_req", 0, 0, 0, 1, 32'h700, 32'hCAFEF00D, 0, FREE));
    v = mk("r_busy", 0, 0, 0, 1, 32'h700, 32'hCAFEF00D, 0, BUSY,
           1, 0, 1, 0, 0, 1, 32'h700, 32'hCAFEF00D);
    driveInputs(v);
    #4;
    checkOutput(v);
    #1;
    nRST = 1'b0;
    #1;
    checkOutput(idle("r_async", 0, 0, 0, 1, 32'h700, 32'hCAFEF00D, 0, BUSY));
    @(posedge CLK);
    #1;
    nRST = 1'b1;
    applyStimulus(idle("r_post", 0, 0, 0, 1, 32'h700, 32'hCAFEF00D, 0, BUSY));
    applyStimulus(mk("r_regrant", 0, 0, 0, 1, 32'h700, 32'hCAFEF00D, 0, BUSY,
                     1, 0, 1, 0, 0, 1, 32'h700, 32'hCAFEF00D));

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
